// File: rtl/vmem_writer.sv
// Captures one raster frame from a valid/ready pixel stream into a frame buffer.
// The write port is registered: each accepted pixel appears on wr_* one cycle later.
module vmem_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        err_sync
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    // Reset asserts asynchronously but is released only on clock edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= '0;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        pix_ready_q, pix_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [18:0] wr_addr_q, wr_addr_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        err_sync_q, err_sync_d;

    logic        accept;
    logic [9:0]  wx;
    logic [8:0]  wy;
    logic        last_pix;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_sync_d   = err_sync_q;
        frame_done_d = 1'b0;

        // abort wins over acceptance, so a pixel offered alongside it is dropped
        accept   = pix_valid && pix_ready_q && !abort;
        // a start-of-frame pixel always lands at the origin
        wx       = pix_sof ? 10'd0 : x_q;
        wy       = pix_sof ? 9'd0  : y_q;
        last_pix = (wx == X_LAST) && (wy == Y_LAST);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = WAIT_SOF;
                        err_sync_d = 1'b0;
                        x_d        = '0;
                        y_d        = '0;
                    end
                end
                WAIT_SOF, WRITE: begin
                    if (accept && (pix_sof || state_q == WRITE)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {wx, wy};
                        wr_data_d = pix_data;
                        if (state_q == WRITE && pix_sof) err_sync_d = 1'b1;
                        if (last_pix) begin
                            state_d = DONE;
                        end else begin
                            state_d = WRITE;
                            if (wx == X_LAST) begin
                                x_d = '0;
                                y_d = wy + 9'd1;
                            end else begin
                                x_d = wx + 10'd1;
                                y_d = wy;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        pix_ready_d = (state_d == WAIT_SOF) || (state_d == WRITE);
        busy_d      = pix_ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            pix_ready_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_ready_q  <= pix_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_sync_q   <= err_sync_d;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_vmem_writer.sv
// Directed bench for vmem_writer; a short frame (640 x 4) keeps full-width x while bounding run time.
module tb_vmem_writer;

    localparam int H = 640;
    localparam int V = 4;
    localparam int N = H * V;

    logic        clk, resetn, start, abort, pix_valid, pix_sof;
    logic [23:0] pix_data;
    logic        pix_ready, wr_en, busy, frame_done, err_sync;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [18:0] log_addr[$];
    logic [23:0] log_data[$];
    int          log_cyc[$];
    int          fd_cnt;
    int          fd_cyc;

    vmem_writer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .pix_ready(pix_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .err_sync(err_sync)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            log_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    function automatic logic [23:0] pdat(input int i);
        return 24'(i * 7 + 'h10203);
    endfunction

    function automatic logic [18:0] raddr(input int i);
        logic [9:0] x;
        logic [8:0] y;
        x = 10'(i % H);
        y = 9'(i / H);
        return {x, y};
    endfunction

    function automatic logic [31:0] la(input int i);
        if (i >= 0 && i < log_addr.size()) return 32'(log_addr[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] ld(input int i);
        if (i >= 0 && i < log_data.size()) return 32'(log_data[i]);
        return 'x;
    endfunction

    function automatic int lc(input int i);
        if (i >= 0 && i < log_cyc.size()) return log_cyc[i];
        return -1;
    endfunction

    // Mismatches of logged addresses [lo,hi) against raster order restarting at lo.
    function automatic int rerr(input int lo, input int hi);
        int e = 0;
        for (int j = lo; j < hi; j++) if (la(j) !== 32'(raddr(j - lo))) e++;
        return e;
    endfunction

    function automatic int derr(input int lo, input int hi);
        int e = 0;
        for (int j = lo; j < hi; j++) if (ld(j) !== 32'(pdat(j - lo))) e++;
        return e;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Back-to-back pixels with pix_valid held high; pix_sof on index 0 and sof2.
    task automatic stream(input int n, input int sof2);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0) || (i == sof2);
            pix_data  = pdat(i);
            step();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    initial begin
        int k, c0, acc, n, trail;
        logic v;

        resetn = 1'b1; start = 1'b0; abort = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        fd_cnt = 0; fd_cyc = -1;
        #1 resetn = 1'b0;
        #2;
        chk("rst_pix_ready", 32'(pix_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy_done_err", {29'd0, busy, frame_done, err_sync}, 0);
        repeat (2) step();
        resetn = 1'b1;
        #1;
        chk("rel_busy", 32'(busy), 0);
        repeat (4) step();

        // leading non-sof pixels are dropped, sof pixel written at origin
        clr();
        pulse_start();
        chk("arm_busy", 32'(busy), 1);
        chk("arm_ready", 32'(pix_ready), 1);
        pix_valid = 1'b1; pix_sof = 1'b0;
        pix_data = 24'h111111; step();
        pix_data = 24'h222222; step();
        pix_data = 24'h333333; step();
        pix_data = 24'hFF0000; pix_sof = 1'b1; c0 = cyc; step();
        pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (2) step();
        chk("sof_nwrites", log_addr.size(), 1);
        chk("sof_addr", la(0), 32'h00000);
        chk("sof_data", ld(0), 32'hFF0000);
        chk("sof_latency", lc(0), c0 + 1);
        abort = 1'b1; step(); abort = 1'b0; step();
        chk("abort_write_busy", 32'(busy), 0);
        chk("abort_write_fd", fd_cnt, 0);

        // full frame, valid held high
        clr();
        pulse_start();
        stream(N, -1);
        repeat (3) step();
        chk("full_nwrites", log_addr.size(), N);
        chk("full_addr_639_0", la(639), 32'h4FE00);
        chk("full_addr_0_1", la(640), 32'h00001);
        chk("full_addr_last", la(N - 1), 32'h4FE03);
        chk("full_raster", rerr(0, N), 0);
        chk("full_data", derr(0, N), 0);
        chk("full_fd_cnt", fd_cnt, 1);
        chk("full_fd_cycle", fd_cyc, lc(N - 1) + 1);
        chk("full_busy_after", 32'(busy), 0);
        chk("full_err", 32'(err_sync), 0);

        // unexpected sof mid-frame at index 1000 (x=360, y=1)
        clr();
        pulse_start();
        stream(1000 + N, 1000);
        repeat (3) step();
        chk("sync_err", 32'(err_sync), 1);
        chk("sync_nwrites", log_addr.size(), 1000 + N);
        chk("sync_addr_999", la(999), 32'h2CE01);
        chk("sync_addr_1000", la(1000), 32'h00000);
        chk("sync_addr_1001", la(1001), 32'h00200);
        chk("sync_raster_pre", rerr(0, 1000), 0);
        chk("sync_raster_post", rerr(1000, 1000 + N), 0);
        chk("sync_fd_cnt", fd_cnt, 1);
        pulse_start();
        chk("sync_err_cleared", 32'(err_sync), 0);
        chk("sync_rearmed", 32'(busy), 1);

        // abort with pixel 500 on the bus: one trailing write only
        clr();
        stream(500, -1);
        pix_valid = 1'b1; pix_data = pdat(500); abort = 1'b1;
        k = cyc;
        step();
        abort = 1'b0; pix_valid = 1'b0;
        repeat (3) step();
        trail = 0;
        foreach (log_cyc[j]) if (log_cyc[j] >= k) trail++;
        chk("abort_nwrites", log_addr.size(), 500);
        chk("abort_trailing", trail, 1);
        chk("abort_trail_addr", la(499), 32'(raddr(499)));
        chk("abort_trail_cycle", lc(499), k);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(pix_ready), 0);
        chk("abort_fd", fd_cnt, 0);

        // start together with abort stays idle
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0; step();
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_ready", 32'(pix_ready), 0);

        // reset with pixel 500 on the bus
        clr();
        pulse_start();
        stream(500, -1);
        pix_valid = 1'b1; pix_data = pdat(500);
        chk("pre_reset_wr_en", 32'(wr_en), 1);
        resetn = 1'b0;
        #1;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(pix_ready), 0);
        chk("reset_addr", 32'(wr_addr), 0);
        pix_valid = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        repeat (5) step();
        chk("reset_nwrites", log_addr.size(), 499);
        chk("reset_fd", fd_cnt, 0);
        chk("reset_busy_after", 32'(busy), 0);

        // random valid gaps, junk on idle cycles, stray start pulses while writing
        clr();
        pulse_start();
        acc = 0;
        n = 0;
        while (acc < N && n < 20000) begin
            v = ($urandom_range(0, 9) < 7);
            pix_valid = v;
            pix_sof   = v ? (acc == 0) : 1'($urandom_range(0, 1));
            pix_data  = v ? pdat(acc) : 24'($urandom);
            start     = (acc > 5) && ($urandom_range(0, 19) == 0);
            step();
            if (v) acc++;
            n++;
        end
        start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        repeat (3) step();
        chk("rand_budget", acc, N);
        chk("rand_nwrites", log_addr.size(), N);
        chk("rand_raster", rerr(0, N), 0);
        chk("rand_data", derr(0, N), 0);
        chk("rand_err", 32'(err_sync), 0);
        chk("rand_fd_cnt", fd_cnt, 1);
        chk("rand_busy_after", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
